// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg
//   Shared types and constants for the PWM playback scheduler.
//   - sched_state_e : scheduler state encoding
//   - SAMPLE_DIV_44K: clk110 cycles per 44 kHz sample period
//   - IDLE_CODE     : DAC mid-scale code driven while not playing
//   - cnt_width()   : bits needed to hold 0..max_val
package pwm_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } sched_state_e;

   localparam int unsigned SAMPLE_DIV_44K = 2500;
   localparam logic [7:0]  IDLE_CODE      = 8'h80;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pwm_playback_sched_sync2.sv
// sync2
//   Generic two-flop single-bit synchronizer with synchronous active-low
//   reset. Used for clk1m1 -> clk110 control bits (e.g. play).
//   Ports:
//     clk   in  destination clock
//     rst_n in  synchronous active-low reset (flops clear to 0)
//     d     in  asynchronous input bit
//     q     out synchronized bit, two clk edges of latency
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pwm_playback_sched.sv
// pwm_playback_sched
//   Moves samples from the 16-bit playback FIFO (read side, clk110) to the
//   8-bit PWM DAC: one pop per sample period, FIFO priming before start,
//   underrun accounting, end-of-stream detection and draining of stale data
//   once play stops. SAMPLE_DIV must be >= 4; SHIFT+7 must be <= 15.
//   Ports:
//     clk110         in   110 MHz clock
//     RESET          in   synchronous active-low reset
//     play           in   play request, asynchronous to clk110
//     fifo_empty_n   in   FIFO holds data; fifo_rd_data valid while high
//     fifo_rd_data   in   FIFO head word
//     fifo_rd        out  one-cycle pop strobe
//     sample         out  DAC code
//     sample_strobe  out  one-cycle pulse when sample takes a new FIFO word
//     dac_enable     out  high while in RUN
//     stream_done    out  one-cycle pulse when underruns end the stream
//     underrun_count out  total missed periods, saturating
//     busy           out  scheduler not IDLE
module pwm_playback_sched
   import pwm_sched_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV     = SAMPLE_DIV_44K,
   parameter int unsigned PRIME_WAIT     = 16,
   parameter int unsigned UNDERRUN_LIMIT = 4,
   parameter int unsigned SHIFT          = 4,
   parameter logic [7:0]  IDLE_VALUE     = IDLE_CODE,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk110,
   input  logic             RESET,
   input  logic             play,
   input  logic             fifo_empty_n,
   input  logic [15:0]      fifo_rd_data,
   output logic             fifo_rd,
   output logic [7:0]       sample,
   output logic             sample_strobe,
   output logic             dac_enable,
   output logic             stream_done,
   output logic [CNT_W-1:0] underrun_count,
   output logic             busy
);

   localparam int unsigned PER_W  = cnt_width(SAMPLE_DIV - 1);
   localparam int unsigned PRM_W  = cnt_width(PRIME_WAIT);
   localparam int unsigned MISS_W = cnt_width(UNDERRUN_LIMIT);

   localparam logic [PER_W-1:0]  PER_LAST   = PER_W'(SAMPLE_DIV - 1);
   localparam logic [PRM_W-1:0]  PRIME_LAST = PRM_W'(PRIME_WAIT - 1);
   localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(UNDERRUN_LIMIT - 1);

   // ---------------------------------------------------------------------
   // play synchronizer and rising-edge detect
   // ---------------------------------------------------------------------
   logic play_s;
   logic play_s_d_q, play_s_d_d;
   logic play_rise;

   sync2 u_play_sync (
      .clk   (clk110),
      .rst_n (RESET),
      .d     (play),
      .q     (play_s)
   );

   assign play_s_d_d = play_s;
   assign play_rise  = play_s & ~play_s_d_q;

   // Only the SHIFT..SHIFT+7 slice is played; the remaining bits are ignored.
   logic unused_rd_bits;
   assign unused_rd_bits = ^fifo_rd_data;

   // ---------------------------------------------------------------------
   // State and counters
   // ---------------------------------------------------------------------
   sched_state_e      state_q, state_d;
   logic [PRM_W-1:0]  prime_cnt_q, prime_cnt_d;
   logic [PER_W-1:0]  period_cnt_q, period_cnt_d;
   logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
   logic              dry_q, dry_d;          // FIFO seen empty last DRAIN cycle
   logic [7:0]        sample_q, sample_d;
   logic              fifo_rd_q, fifo_rd_d;
   logic              sample_strobe_q, sample_strobe_d;
   logic              dac_enable_q, dac_enable_d;
   logic              stream_done_q, stream_done_d;
   logic [CNT_W-1:0]  underrun_count_q, underrun_count_d;
   logic              busy_q, busy_d;
   logic              tick;

   assign tick = (period_cnt_q == PER_LAST);

   always_comb begin
      state_d          = state_q;
      prime_cnt_d      = prime_cnt_q;
      period_cnt_d     = period_cnt_q;
      miss_cnt_d       = miss_cnt_q;
      dry_d            = dry_q;
      sample_d         = sample_q;
      fifo_rd_d        = 1'b0;
      sample_strobe_d  = 1'b0;
      stream_done_d    = 1'b0;
      underrun_count_d = underrun_count_q;

      case (state_q)
         IDLE: begin
            // Only a fresh edge starts playback; a level left high after
            // end of stream does not.
            if (play_rise) begin
               state_d     = PRIME;
               prime_cnt_d = '0;
            end
         end

         PRIME: begin
            if (!play_s) begin
               state_d = DRAIN;
               dry_d   = 1'b0;
            end else if (fifo_empty_n) begin
               prime_cnt_d = prime_cnt_q + 1'b1;
               if (prime_cnt_q == PRIME_LAST) begin
                  state_d      = RUN;
                  period_cnt_d = '0;
                  miss_cnt_d   = '0;
               end
            end else begin
               // Data must be present continuously; any gap restarts priming.
               prime_cnt_d = '0;
            end
         end

         RUN: begin
            // A stop request outranks a coincident tick: no pop, no count.
            if (!play_s) begin
               state_d = DRAIN;
               dry_d   = 1'b0;
            end else begin
               period_cnt_d = tick ? '0 : period_cnt_q + 1'b1;
               if (tick) begin
                  if (fifo_empty_n) begin
                     sample_d        = fifo_rd_data[SHIFT+7:SHIFT];
                     fifo_rd_d       = 1'b1;
                     sample_strobe_d = 1'b1;
                     miss_cnt_d      = '0;
                  end else begin
                     if (underrun_count_q != '1)
                        underrun_count_d = underrun_count_q + 1'b1;
                     miss_cnt_d = miss_cnt_q + 1'b1;
                     if (miss_cnt_q == MISS_LAST) begin
                        stream_done_d = 1'b1;
                        state_d       = DRAIN;
                        dry_d         = 1'b0;
                     end
                  end
               end
            end
         end

         DRAIN: begin
            // Skip a cycle after each pop so the FIFO flag can catch up.
            fifo_rd_d = fifo_empty_n & ~fifo_rd_q;
            if (fifo_empty_n) begin
               dry_d = 1'b0;
            end else if (dry_q) begin
               state_d = IDLE;
               dry_d   = 1'b0;
            end else begin
               dry_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      if (state_d != RUN)
         sample_d = IDLE_VALUE;
      dac_enable_d = (state_d == RUN);
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk110) begin
      if (!RESET) begin
         state_q          <= IDLE;
         play_s_d_q       <= 1'b0;
         prime_cnt_q      <= '0;
         period_cnt_q     <= '0;
         miss_cnt_q       <= '0;
         dry_q            <= 1'b0;
         sample_q         <= IDLE_VALUE;
         fifo_rd_q        <= 1'b0;
         sample_strobe_q  <= 1'b0;
         dac_enable_q     <= 1'b0;
         stream_done_q    <= 1'b0;
         underrun_count_q <= '0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         play_s_d_q       <= play_s_d_d;
         prime_cnt_q      <= prime_cnt_d;
         period_cnt_q     <= period_cnt_d;
         miss_cnt_q       <= miss_cnt_d;
         dry_q            <= dry_d;
         sample_q         <= sample_d;
         fifo_rd_q        <= fifo_rd_d;
         sample_strobe_q  <= sample_strobe_d;
         dac_enable_q     <= dac_enable_d;
         stream_done_q    <= stream_done_d;
         underrun_count_q <= underrun_count_d;
         busy_q           <= busy_d;
      end
   end

   assign fifo_rd        = fifo_rd_q;
   assign sample         = sample_q;
   assign sample_strobe  = sample_strobe_q;
   assign dac_enable     = dac_enable_q;
   assign stream_done    = stream_done_q;
   assign underrun_count = underrun_count_q;
   assign busy           = busy_q;

endmodule
